muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the RV64M extension. It sits beside the single-cycle ALU in the execute stage. It accepts one decoded M-extension operation (the 4-bit mulOp code plus two 64-bit operands) and runs a shift-add multiply or restoring divide over many cycles. It stalls the pipeline until the result is ready, then pulses `done` with the 64-bit writeback value.

---
 rtl/muldiv_seq.sv | 158 +++++++++++++++
 tb/tb_muldiv_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer: shift-add multiply, restoring divide.
// Stalls the execute stage until a one-cycle done pulse carries the writeback value.
module muldiv_seq #(
  parameter int unsigned MUL_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  mulOp,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam logic [6:0] C_MUL64 = 7'(64 / MUL_STEP - 1);
  localparam logic [6:0] C_MUL32 = 7'(32 / MUL_STEP - 1);

  state_t      r_state, w_next;
  logic [6:0]  r_cnt;
  logic        r_w, r_div, r_rem, r_qneg, r_rneg;
  logic [63:0] r_x, r_y, r_acc, r_result;

  logic        w_accept, w_isw, w_isdiv, w_signed, w_sa, w_sb;
  logic        w_divz, w_ovf, w_special, w_qbit;
  logic [63:0] w_ea, w_eb, w_abs_a, w_abs_b, w_spec_res, w_mul_acc;
  logic [63:0] w_q, w_r, w_fix;
  logic [64:0] w_sh, w_diff;

  function automatic logic [63:0] f_wfix(input logic isw, input logic [63:0] v);
    return isw ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  assign w_isw    = mulOp[3];
  assign w_isdiv  = mulOp[2];
  assign w_signed = mulOp[2] & ~mulOp[0];
  assign w_accept = (r_state == S_IDLE) & valid & ~flush;

  always_comb begin
    if (w_isw) begin
      w_ea = w_signed ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
      w_eb = w_signed ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
    end else begin
      w_ea = a;
      w_eb = b;
    end
  end

  assign w_sa      = w_signed & w_ea[63];
  assign w_sb      = w_signed & w_eb[63];
  assign w_abs_a   = w_sa ? -w_ea : w_ea;
  assign w_abs_b   = w_sb ? -w_eb : w_eb;
  assign w_divz    = (w_eb == '0);
  assign w_ovf     = w_signed & (w_eb == '1) &
                     (w_ea == (w_isw ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  assign w_special = w_isdiv & (w_divz | w_ovf);

  always_comb begin
    if (w_divz) w_spec_res = mulOp[1] ? w_ea : '1;
    else        w_spec_res = mulOp[1] ? '0   : w_ea;
    w_spec_res = f_wfix(w_isw, w_spec_res);
  end

  // Multiply step: retire MUL_STEP multiplier bits, multiplicand pre-shifted each cycle.
  always_comb begin
    w_mul_acc = r_acc;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (r_y[i]) w_mul_acc = w_mul_acc + (r_x << i);
    end
  end

  // Restoring divide: r_x shifts dividend out at the top and quotient bits in at the bottom.
  assign w_sh   = {r_acc, r_x[63]};
  assign w_diff = w_sh - {1'b0, r_y};
  assign w_qbit = ~w_diff[64];

  assign w_q   = r_qneg ? -r_x : r_x;
  assign w_r   = r_rneg ? -r_acc : r_acc;
  assign w_fix = f_wfix(r_w, r_div ? (r_rem ? w_r : w_q) : r_acc);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (valid) w_next = w_special ? S_DONE : (w_isdiv ? S_DIV : S_MUL);
      S_MUL:  if (r_cnt == '0) w_next = S_FIX;
      S_DIV:  if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_comb begin
    done  = (r_state == S_DONE) & ~flush;
    stall = valid & ~done;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_w      <= 1'b0;
      r_div    <= 1'b0;
      r_rem    <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_w    <= w_isw;
      r_div  <= w_isdiv;
      r_rem  <= mulOp[1];
      r_qneg <= w_sa ^ w_sb;
      r_rneg <= w_sa;
      r_acc  <= '0;
      if (w_isdiv) begin
        r_x   <= w_isw ? {w_abs_a[31:0], 32'b0} : w_abs_a;
        r_y   <= w_abs_b;
        r_cnt <= w_isw ? 7'd31 : 7'd63;
      end else begin
        r_x   <= w_ea;
        r_y   <= w_eb;
        r_cnt <= w_isw ? C_MUL32 : C_MUL64;
      end
      if (w_special) r_result <= w_spec_res;
    end else begin
      case (r_state)
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_x   <= r_x << MUL_STEP;
          r_y   <= r_y >> MUL_STEP;
          r_cnt <= r_cnt - 7'd1;
        end
        S_DIV: begin
          r_acc <= w_qbit ? w_diff[63:0] : w_sh[63:0];
          r_x   <= {r_x[62:0], w_qbit};
          r_cnt <= r_cnt - 7'd1;
        end
        S_FIX: if (!flush) r_result <= w_fix;
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vectors, abort/back-to-back sequences,
// and random ops against an arithmetic reference model.
module tb_muldiv_seq;

  localparam int STEP = 1;

  logic        clk, reset, valid, flush;
  logic [3:0]  mulOp;
  logic [63:0] a, b;
  logic        stall, done;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_seq #(.MUL_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .valid(valid), .mulOp(mulOp), .a(a), .b(b),
    .flush(flush), .stall(stall), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic [7:0]  lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] p, ux, uy;
    longint      sx, sy;
    int          s32x, s32y;
    int unsigned u32x, u32y;
    logic [31:0] r32;
    if (!op[2]) begin
      p = x * y;
      return op[3] ? {{32{p[31]}}, p[31:0]} : p;
    end
    if (op[3]) begin
      if (op[0]) begin
        u32x = x[31:0]; u32y = y[31:0];
        if (u32y == 0) r32 = op[1] ? u32x : 32'hFFFF_FFFF;
        else           r32 = op[1] ? (u32x % u32y) : (u32x / u32y);
      end else begin
        s32x = x[31:0]; s32y = y[31:0];
        if (s32y == 0) r32 = op[1] ? s32x : 32'hFFFF_FFFF;
        else if (s32x == 32'sh8000_0000 && s32y == -1) r32 = op[1] ? 32'h0 : s32x;
        else           r32 = op[1] ? (s32x % s32y) : (s32x / s32y);
      end
      return {{32{r32[31]}}, r32};
    end
    if (op[0]) begin
      ux = x; uy = y;
      if (uy == 0) return op[1] ? ux : '1;
      return op[1] ? (ux % uy) : (ux / uy);
    end
    sx = x; sy = y;
    if (sy == 0) return op[1] ? x : '1;
    if (sx == 64'sh8000_0000_0000_0000 && sy == -1) return op[1] ? 64'h0 : x;
    return op[1] ? 64'(sx % sy) : 64'(sx / sy);
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    logic zero, ovf;
    if (!op[2]) return (op[3] ? 32 : 64) / STEP + 2;
    zero = op[3] ? (y[31:0] == 32'h0) : (y == 64'h0);
    ovf  = !op[0] && (op[3] ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
                            : (x == 64'h8000_0000_0000_0000 && y == '1));
    if (zero || ovf) return 1;
    return op[3] ? 34 : 66;
  endfunction

  // Starts #1 after a rising edge; that cycle is cycle 0 of the operation.
  task automatic do_op(input string nm, input logic [3:0] op, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] exp, input int exp_lat);
    int c, lat, sbad;
    logic [63:0] res;
    c = 0; lat = -1; sbad = 0; res = '0;
    valid = 1'b1; mulOp = op; a = x; b = y;
    while (lat < 0 && c < 400) begin
      @(negedge clk);
      if (stall !== (c < exp_lat)) sbad++;
      if (done === 1'b1) begin lat = c; res = result; end
      @(posedge clk); #1;
      c++;
    end
    valid = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " result"}, res, exp);
    chk({nm, " stall"}, 64'(sbad), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    logic [63:0] prev, x, y;
    logic [3:0]  op;
    int          sawd;

    vecs[0] = '{op: 4'b0000, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd3, exp: 64'hFFFF_FFFF_FFFF_FFFD, lat: 8'd66};
    vecs[1] = '{op: 4'b0100, a: -64'sd7, b: 64'd2, exp: 64'hFFFF_FFFF_FFFF_FFFD, lat: 8'd66};
    vecs[2] = '{op: 4'b0110, a: -64'sd7, b: 64'd2, exp: 64'hFFFF_FFFF_FFFF_FFFF, lat: 8'd66};
    vecs[3] = '{op: 4'b0101, a: 64'd5, b: 64'd0, exp: 64'hFFFF_FFFF_FFFF_FFFF, lat: 8'd1};
    vecs[4] = '{op: 4'b0111, a: 64'd5, b: 64'd0, exp: 64'd5, lat: 8'd1};
    vecs[5] = '{op: 4'b1100, a: 64'h8000_0000, b: 64'hFFFF_FFFF, exp: 64'hFFFF_FFFF_8000_0000, lat: 8'd1};
    vecs[6] = '{op: 4'b1101, a: 64'h1234_5678_FFFF_FFFF, b: 64'd1, exp: 64'hFFFF_FFFF_FFFF_FFFF, lat: 8'd34};
    vecs[7] = '{op: 4'b1111, a: 64'd7, b: 64'd2, exp: 64'd1, lat: 8'd34};
    vecs[8] = '{op: 4'b1000, a: 64'h7FFF_FFFF, b: 64'd2, exp: 64'hFFFF_FFFF_FFFF_FFFE, lat: 8'd34};
    vecs[9] = '{op: 4'b1110, a: 64'h0000_0000_FFFF_FFF9, b: 64'd2, exp: 64'hFFFF_FFFF_FFFF_FFFF, lat: 8'd34};

    reset = 1'b0; valid = 1'b1; flush = 1'b0; mulOp = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset done", {63'b0, done}, 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset stall follows valid=1", {63'b0, stall}, 64'd1);
    valid = 1'b0;
    #1;
    chk("reset stall follows valid=0", {63'b0, stall}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, int'(vecs[i].lat));
      @(posedge clk); #1;
    end

    // flush mid-divide, then a mul accepted in cycle 11
    prev = result; sawd = 0;
    valid = 1'b1; mulOp = 4'b0100; a = 64'd100; b = 64'd7;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) flush = 1'b1;
      @(negedge clk);
      if (done === 1'b1) sawd++;
      if (c == 10) chk("flush result held", result, prev);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    chk("flush no done", 64'(sawd), 64'd0);
    do_op("mul after flush", 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    @(posedge clk); #1;

    // reset mid-divide
    sawd = 0;
    valid = 1'b1; mulOp = 4'b0100; a = 64'd100; b = 64'd7;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) reset = 1'b0;
      @(negedge clk);
      if (done === 1'b1) sawd++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    chk("reset mid-op no done", 64'(sawd), 64'd0);
    chk("reset mid-op result", result, 64'd0);
    do_op("mul after reset", 4'b0000, 64'd6, 64'd7, 64'd42, 66);
    @(posedge clk); #1;

    // flush landing on the done cycle of a special case suppresses done
    valid = 1'b1; mulOp = 4'b0101; a = 64'd5; b = 64'd0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush in done cycle", {63'b0, done}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("idle after flushed done", {63'b0, done}, 64'd0);
    @(posedge clk); #1;

    // back-to-back: div accepted in the cycle right after the mul's done
    do_op("b2b mul", 4'b0000, 64'd123456789, 64'd1000, 64'd123456789000, 66);
    do_op("b2b div", 4'b0100, 64'd1000, -64'sd7, -64'sd142, 66);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: y = '0;
        1: begin y = '1; x = op[3] ? 64'h8000_0000 : 64'h8000_0000_0000_0000; end
        2: y = 64'($urandom_range(1, 9));
        3: begin x = -64'($urandom_range(1, 1000)); y = 64'($urandom_range(1, 13)); end
        default: ;
      endcase
      do_op($sformatf("rand%0d op=%b", i, op), op, x, y, ref_model(op, x, y), ref_lat(op, x, y));
      @(negedge clk);
      chk($sformatf("rand%0d single pulse", i), {63'b0, done}, 64'd0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
